// File: rtl/ecu_pkg.sv
// Shared ECU definitions: bus widths, fetch FSM states and opcode length decode.
package ecu_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    INC  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Instruction length in bytes from the top two opcode bits.
  function automatic logic [1:0] op_len(input logic [1:0] op_hi);
    logic [1:0] len;
    case (op_hi)
      2'b00:   len = 2'd1;
      2'b01:   len = 2'd2;
      default: len = 2'd3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ifetch.sv
// Instruction fetch sequencer: drives the PC/memory read handshake byte by byte
// and hands an assembled instruction to decode over a valid/ready handshake.
module ifetch
  import ecu_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            flush,
  input  logic [AW-1:0]   ai,
  output logic            pc_oe,
  output logic            pc_ini,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_rd,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_data,
  output logic [3*DW-1:0] ir,
  output logic [1:0]      ir_len,
  output logic            ir_valid,
  input  logic            ir_ready
);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [3*DW-1:0] ir_q, ir_d;
  logic [1:0]      ir_len_q, ir_len_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    ir_len_d = ir_len_q;
    if (flush) begin
      // PC is being reloaded: drop any partial instruction.
      state_d  = IDLE;
      cnt_d    = '0;
      ir_d     = '0;
      ir_len_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (run) begin
            state_d = REQ;
            cnt_d   = '0;
            ir_d    = '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            for (int i = 0; i < 3; i++) begin
              if (cnt_q == 2'(i)) ir_d[i*DW +: DW] = mem_data;
            end
            if (cnt_q == 2'd0) ir_len_d = op_len(mem_data[DW-1 -: 2]);
            cnt_d   = cnt_q + 2'd1;
            state_d = INC;
          end
        end
        INC: begin
          state_d = (cnt_q == ir_len_q) ? HOLD : REQ;
        end
        HOLD: begin
          if (ir_ready) begin
            state_d = run ? REQ : IDLE;
            cnt_d   = '0;
            ir_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ir_q     <= '0;
      ir_len_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      ir_len_q <= ir_len_d;
    end
  end

  // Strobes are suppressed in a flush cycle so no byte or increment escapes.
  assign pc_oe    = (state_q == REQ) || (state_q == INC);
  assign mem_rd   = (state_q == REQ) && !flush;
  assign pc_ini   = (state_q == INC) && !flush;
  assign ir_valid = (state_q == HOLD) && !flush;
  assign mem_addr = (state_q == REQ) ? ai : '0;
  assign ir       = ir_q;
  assign ir_len   = ir_len_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed + randomized bench for ifetch with a PC model, a byte-array memory
// with random wait states, and an instruction-level reference model.
module tb_ifetch;

  localparam int AW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic            flush = 1'b0;
  logic            mem_ack = 1'b0;
  logic            ir_ready = 1'b0;
  logic [DW-1:0]   mem_data = '0;
  logic [AW-1:0]   ai;
  logic            pc_oe, pc_ini, mem_rd, ir_valid;
  logic [AW-1:0]   mem_addr;
  logic [3*DW-1:0] ir;
  logic [1:0]      ir_len;

  ifetch #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .run(run), .flush(flush), .ai(ai),
    .pc_oe(pc_oe), .pc_ini(pc_ini), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_ack(mem_ack), .mem_data(mem_data), .ir(ir), .ir_len(ir_len),
    .ir_valid(ir_valid), .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  memv [256];
  logic [15:0] pc = 16'h1234;
  logic        ld = 1'b0;
  logic [15:0] ld_val = '0;
  int          ini_cnt = 0;
  logic        prev_ini = 1'b0;
  logic        prev_rd = 1'b0;
  logic [15:0] prev_addr = '0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic [23:0] last_ir = '0;

  assign ai = pc;

  always @(posedge clk) begin
    if (ld) pc <= ld_val;
    else if (pc_ini) pc <= pc + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Protocol monitor
  always @(negedge clk) begin
    if (pc_ini) begin
      ini_cnt++;
      chk("ini_gap", 32'(prev_ini), 0);
    end
    if (mem_rd) chk("addr_pass", 32'(mem_addr), 32'(ai));
    if (mem_rd && prev_rd) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
    prev_ini  = pc_ini;
    prev_rd   = mem_rd;
    prev_addr = mem_addr;
  end

  // Memory: wait_n idle cycles then ack; random junk acks when not requested.
  always @(negedge clk) begin
    if (mem_rd) begin
      if (wcnt >= wait_n) begin
        mem_ack  = 1'b1;
        mem_data = memv[mem_addr[7:0]];
        wcnt     = 0;
      end else begin
        mem_ack  = 1'b0;
        mem_data = 8'($urandom);
        wcnt++;
      end
    end else begin
      mem_ack  = ($urandom_range(0, 3) == 0);
      mem_data = 8'($urandom);
      wcnt     = 0;
    end
  end

  task automatic load_pc(input logic [15:0] v);
    ld_val = v;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  // One whole instruction, started from IDLE (run) or from HOLD (ir_ready).
  task automatic fetch(input int w, input bit from_hold, input bit drop_run);
    logic [15:0] pc0;
    logic [23:0] exp_ir;
    logic [7:0]  op;
    int len, cyc, ini0;
    pc0  = pc;
    ini0 = ini_cnt;
    wait_n = w;
    op  = memv[pc0[7:0]];
    len = (op >= 8'h80) ? 3 : (op >= 8'h40) ? 2 : 1;
    exp_ir = '0;
    for (int i = 0; i < len; i++)
      exp_ir |= 24'(memv[8'(32'(pc0[7:0]) + i)]) << (8 * i);
    last_ir = exp_ir;
    if (from_hold) ir_ready = 1'b1;
    run = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      ir_ready = 1'b0;
      cyc++;
      if (cyc == 1) begin
        chk("req_next", 32'(mem_rd), 1);
        chk("req_addr", 32'(mem_addr), 32'(pc0));
      end
      if (drop_run && pc_ini) run = 1'b0;
    end while (!ir_valid && cyc < 200);
    chk("latency", cyc, len * (w + 2) + 1);
    chk("ir", 32'(ir), 32'(exp_ir));
    chk("ir_len", 32'(ir_len), len);
    chk("ini_pulses", ini_cnt - ini0, len);
    chk("pc_adv", 32'(pc), 32'(pc0) + len);
  endtask

  task automatic go_idle();
    run = 1'b0;
    ir_ready = 1'b1;
    @(negedge clk);
    ir_ready = 1'b0;
    chk("idle_valid", 32'(ir_valid), 0);
    chk("idle_ir", 32'(ir), 0);
    repeat (4) begin
      @(negedge clk);
      chk("idle_rd", 32'(mem_rd), 0);
      chk("idle_oe", 32'(pc_oe), 0);
    end
  endtask

  initial begin
    int ini0, cyc;
    for (int i = 0; i < 256; i++) memv[i] = 8'($urandom);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd", 32'(mem_rd), 0);
    chk("rst_oe", 32'(pc_oe), 0);
    chk("rst_ini", 32'(pc_ini), 0);
    chk("rst_valid", 32'(ir_valid), 0);
    chk("rst_ir", 32'(ir), 0);
    chk("rst_len", 32'(ir_len), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    rst = 1'b0;

    // 1-byte, zero wait
    load_pc(16'h800A);
    memv[8'h0A] = 8'h12;
    fetch(0, 1'b0, 1'b0);

    // Backpressure in HOLD
    ini0 = ini_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 32'(ir_valid), 1);
      chk("bp_ir", 32'(ir), 32'(last_ir));
      chk("bp_rd", 32'(mem_rd), 0);
    end
    chk("bp_ini", ini_cnt - ini0, 0);

    // 3-byte with two wait cycles per byte, released from HOLD
    load_pc(16'h8000);
    memv[8'h00] = 8'h80;
    memv[8'h01] = 8'h34;
    memv[8'h02] = 8'h56;
    fetch(2, 1'b1, 1'b0);
    chk("ir_3b", 32'(ir), 32'h563480);

    // Random back-to-back stream
    for (int k = 0; k < 8; k++) fetch(int'($urandom_range(0, 3)), 1'b1, 1'b0);
    go_idle();

    // Flush coincident with the second byte's ack
    load_pc(16'h8040);
    memv[8'h40] = 8'h40;
    memv[8'h41] = 8'h99;
    wait_n = 0;
    ini0 = ini_cnt;
    run = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_rd && ini_cnt > ini0) && cyc < 50);
    chk("fl_reach", cyc, 3);
    #1 flush = 1'b1;
    run = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_rd", 32'(mem_rd), 0);
    chk("fl_oe", 32'(pc_oe), 0);
    chk("fl_ir", 32'(ir), 0);
    chk("fl_len", 32'(ir_len), 0);
    chk("fl_ini", ini_cnt - ini0, 1);
    chk("fl_pc", 32'(pc), 32'h8041);
    repeat (5) begin
      @(negedge clk);
      chk("fl_novalid", 32'(ir_valid), 0);
      chk("fl_idle_rd", 32'(mem_rd), 0);
    end

    // run dropped after the first byte of a 3-byte instruction
    load_pc(16'h8060);
    memv[8'h60] = 8'hC5;
    memv[8'h61] = 8'h11;
    memv[8'h62] = 8'h22;
    fetch(1, 1'b0, 1'b1);
    go_idle();

    // Async reset while a read is pending
    load_pc(16'h8070);
    wait_n = 6;
    run = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_rst_rd", 32'(mem_rd), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rd", 32'(mem_rd), 0);
    chk("arst_oe", 32'(pc_oe), 0);
    chk("arst_ini", 32'(pc_ini), 0);
    chk("arst_valid", 32'(ir_valid), 0);
    chk("arst_addr", 32'(mem_addr), 0);
    chk("arst_len", 32'(ir_len), 0);
    run = 1'b0;
    ini0 = ini_cnt;
    repeat (3) @(negedge clk);
    chk("arst_noini", ini_cnt - ini0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rd", 32'(mem_rd), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
